// File: rtl/fu_inc_arb.sv
// Two-requester arbitrated 56-bit incrementer: s1 registers operand and byte all-ones flags, s2 holds result.
// Define FU_INC_ARB_RR_EN for round-robin contention handling; otherwise requester A always wins.
module fu_inc_arb (
  input  logic        nclk,
  input  logic        reset_b,
  input  logic        a_req_v,
  input  logic [0:55] a_req_data,
  input  logic [0:3]  a_req_tag,
  output logic        a_req_rdy,
  input  logic        b_req_v,
  input  logic [0:55] b_req_data,
  input  logic [0:3]  b_req_tag,
  output logic        b_req_rdy,
  input  logic        out_take,
  output logic        out_v,
  output logic [0:55] out_data,
  output logic        out_all1,
  output logic [0:3]  out_tag,
  output logic        out_src,
  output logic        busy
);

  logic        s1_v_q, s1_v_d;
  logic [0:55] s1_data_q, s1_data_d;
  logic [0:6]  s1_g1_q, s1_g1_d;
  logic [0:3]  s1_tag_q, s1_tag_d;
  logic        s1_src_q, s1_src_d;

  logic        s2_v_q, s2_v_d;
  logic [0:55] s2_data_q, s2_data_d;
  logic        s2_all1_q, s2_all1_d;
  logic [0:3]  s2_tag_q, s2_tag_d;
  logic        s2_src_q, s2_src_d;

  logic        advance, s1_free, grant_a, grant_b, accept;
  logic [0:55] sel_data;
  logic [3:0][7:0] pfx;

`ifdef FU_INC_ARB_RR_EN
  logic rr_q, rr_d;
  logic contend;

  always_comb begin
    contend = a_req_v & b_req_v;
    grant_b = contend ? rr_q : b_req_v;
    grant_a = a_req_v & ~grant_b;
    rr_d    = rr_q ^ (contend & accept);
  end

  always_ff @(posedge nclk or negedge reset_b) begin
    if (!reset_b) rr_q <= 1'b0;
    else          rr_q <= rr_d;
  end
`else
  always_comb begin
    grant_b = b_req_v & ~a_req_v;
    grant_a = a_req_v;
  end
`endif

  always_comb begin
    advance   = ~s2_v_q | out_take;
    s1_free   = ~s1_v_q | advance;
    a_req_rdy = reset_b & s1_free & grant_a;
    b_req_rdy = reset_b & s1_free & grant_b;
    accept    = a_req_rdy | b_req_rdy;
    sel_data  = grant_b ? b_req_data : a_req_data;
  end

  always_comb begin
    s1_v_d    = s1_v_q;
    s1_data_d = s1_data_q;
    s1_g1_d   = s1_g1_q;
    s1_tag_d  = s1_tag_q;
    s1_src_d  = s1_src_q;
    if (s1_free) begin
      s1_v_d = accept;
      if (accept) begin
        s1_data_d = sel_data;
        s1_tag_d  = grant_b ? b_req_tag : a_req_tag;
        s1_src_d  = grant_b;
        for (int k = 0; k < 7; k++) s1_g1_d[k] = &sel_data[8*k +: 8];
      end
    end
  end

  // Prefix AND indexed from the least significant byte; entry 0 is the constant
  // carry into byte 6. Eight entries need only spans 1, 2 and 4 (span 8 is empty).
  always_comb begin
    pfx = '0;
    pfx[0][0] = 1'b1;
    for (int j = 1; j < 8; j++) pfx[0][j] = s1_g1_q[7-j];
    for (int l = 0; l < 3; l++) begin
      for (int j = 0; j < 8; j++) begin
        if (j >= (1 << l)) pfx[l+1][j] = pfx[l][j] & pfx[l][j-(1 << l)];
        else               pfx[l+1][j] = pfx[l][j];
      end
    end
  end

  always_comb begin
    s2_v_d    = s2_v_q;
    s2_data_d = s2_data_q;
    s2_all1_d = s2_all1_q;
    s2_tag_d  = s2_tag_q;
    s2_src_d  = s2_src_q;
    if (advance) begin
      s2_v_d = s1_v_q;
      if (s1_v_q) begin
        for (int k = 0; k < 7; k++)
          s2_data_d[8*k +: 8] = s1_data_q[8*k +: 8] + {7'd0, pfx[3][6-k]};
        s2_all1_d = pfx[3][7];
        s2_tag_d  = s1_tag_q;
        s2_src_d  = s1_src_q;
      end
    end
  end

  always_ff @(posedge nclk or negedge reset_b) begin
    if (!reset_b) begin
      s1_v_q    <= 1'b0;
      s1_data_q <= '0;
      s1_g1_q   <= '0;
      s1_tag_q  <= '0;
      s1_src_q  <= 1'b0;
      s2_v_q    <= 1'b0;
      s2_data_q <= '0;
      s2_all1_q <= 1'b0;
      s2_tag_q  <= '0;
      s2_src_q  <= 1'b0;
    end else begin
      s1_v_q    <= s1_v_d;
      s1_data_q <= s1_data_d;
      s1_g1_q   <= s1_g1_d;
      s1_tag_q  <= s1_tag_d;
      s1_src_q  <= s1_src_d;
      s2_v_q    <= s2_v_d;
      s2_data_q <= s2_data_d;
      s2_all1_q <= s2_all1_d;
      s2_tag_q  <= s2_tag_d;
      s2_src_q  <= s2_src_d;
    end
  end

  assign out_v    = s2_v_q;
  assign out_data = s2_data_q;
  assign out_all1 = s2_all1_q;
  assign out_tag  = s2_tag_q;
  assign out_src  = s2_src_q;
  assign busy     = s1_v_q | s2_v_q;

endmodule

// File: tb/tb_fu_inc_arb.sv
// Bench for fu_inc_arb: timestamped queue model checked every cycle, plus directed literal expectations.
module tb_fu_inc_arb;

  logic        nclk = 1'b0;
  logic        reset_b = 1'b0;
  logic        a_req_v = 1'b0, b_req_v = 1'b0, out_take = 1'b0;
  logic [0:55] a_req_data = '0, b_req_data = '0;
  logic [0:3]  a_req_tag = '0, b_req_tag = '0;
  logic        a_req_rdy, b_req_rdy, out_v, out_all1, out_src, busy;
  logic [0:55] out_data;
  logic [0:3]  out_tag;

  fu_inc_arb dut (
    .nclk(nclk), .reset_b(reset_b),
    .a_req_v(a_req_v), .a_req_data(a_req_data), .a_req_tag(a_req_tag), .a_req_rdy(a_req_rdy),
    .b_req_v(b_req_v), .b_req_data(b_req_data), .b_req_tag(b_req_tag), .b_req_rdy(b_req_rdy),
    .out_take(out_take), .out_v(out_v), .out_data(out_data), .out_all1(out_all1),
    .out_tag(out_tag), .out_src(out_src), .busy(busy)
  );

  always #5 nclk = ~nclk;

  typedef struct {
    logic [55:0] res;
    logic        all1;
    logic [3:0]  tag;
    logic        src;
    int          ready;
  } item_t;

  item_t q[$];
  int    cyc = 0;
  bit    ptr = 1'b0;
  int    n_checks = 0;
  int    n_pass = 0;

  function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
  endfunction

  // Model: each request becomes visible two cycles after acceptance, or one cycle
  // after the request ahead of it is taken, whichever is later. Capacity is two.
  always @(negedge nclk) begin : compare
    bit head_vis, s1occ, adv, free, gb, ga, acc;
    logic [55:0] din;
    logic [56:0] sum;
    item_t it;
    if (!reset_b) begin
      check("rst_out_v", 64'(out_v), 64'd0);
      check("rst_busy", 64'(busy), 64'd0);
      check("rst_a_rdy", 64'(a_req_rdy), 64'd0);
      check("rst_b_rdy", 64'(b_req_rdy), 64'd0);
      check("rst_out_data", 64'(out_data), 64'd0);
      check("rst_out_all1", 64'(out_all1), 64'd0);
      check("rst_out_tag", 64'(out_tag), 64'd0);
      check("rst_out_src", 64'(out_src), 64'd0);
      q.delete();
      ptr = 1'b0;
    end else begin
      head_vis = (q.size() > 0) && (q[0].ready <= cyc);
      s1occ    = q.size() > (head_vis ? 1 : 0);
      adv      = !head_vis || out_take;
      free     = !s1occ || adv;
      if (a_req_v && b_req_v) begin
`ifdef FU_INC_ARB_RR_EN
        gb = ptr;
`else
        gb = 1'b0;
`endif
      end else begin
        gb = b_req_v;
      end
      ga  = a_req_v && !gb;
      acc = free && (ga || gb);
      check("cyc_out_v", 64'(out_v), 64'(head_vis));
      check("cyc_busy", 64'(busy), 64'(q.size() > 0));
      check("cyc_a_rdy", 64'(a_req_rdy), 64'(free && ga));
      check("cyc_b_rdy", 64'(b_req_rdy), 64'(free && gb));
      if (head_vis) begin
        check("cyc_out_data", 64'(out_data), 64'(q[0].res));
        check("cyc_out_all1", 64'(out_all1), 64'(q[0].all1));
        check("cyc_out_tag", 64'(out_tag), 64'(q[0].tag));
        check("cyc_out_src", 64'(out_src), 64'(q[0].src));
      end
      if (head_vis && out_take) begin
        void'(q.pop_front());
        if (q.size() > 0 && q[0].ready < cyc + 1) q[0].ready = cyc + 1;
      end
      if (acc) begin
        din      = gb ? b_req_data : a_req_data;
        sum      = {1'b0, din} + 57'd1;
        it.res   = sum[55:0];
        it.all1  = sum[56];
        it.tag   = gb ? b_req_tag : a_req_tag;
        it.src   = gb;
        it.ready = cyc + 2;
        q.push_back(it);
        if (a_req_v && b_req_v) ptr = ~ptr;
      end
    end
    cyc++;
  end

  task automatic tick();
    @(posedge nclk);
    #1;
  endtask

  task automatic apply_stimulus(input logic av, input logic [55:0] ad, input logic [3:0] at,
                                input logic bv, input logic [55:0] bd, input logic [3:0] bt,
                                input logic take);
    a_req_v = av; a_req_data = ad; a_req_tag = at;
    b_req_v = bv; b_req_data = bd; b_req_tag = bt;
    out_take = take;
  endtask

  task automatic check_output(input string name, input logic [55:0] d, input logic a1,
                              input logic [3:0] t, input logic s, output int waited);
    waited = 0;
    @(negedge nclk);
    while (out_v !== 1'b1 && waited < 8) begin
      waited++;
      @(negedge nclk);
    end
    check({name, "_valid"}, 64'(out_v), 64'd1);
    check({name, "_data"}, 64'(out_data), 64'(d));
    check({name, "_all1"}, 64'(out_all1), 64'(a1));
    check({name, "_tag"}, 64'(out_tag), 64'(t));
    check({name, "_src"}, 64'(out_src), 64'(s));
  endtask

  initial begin : watchdog
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin : stim
    logic [3:0] apat, bpat;
    int w;
    repeat (2) tick();
    check("rst_idle_out_v", 64'(out_v), 64'd0);

    // Contention directly after reset release; also proves first-cycle acceptance.
    reset_b = 1'b1;
    apply_stimulus(1, 56'h11, 4'h1, 1, 56'h22, 4'h2, 1);
    for (int i = 0; i < 4; i++) begin
      @(negedge nclk);
      apat[i] = a_req_rdy | b_req_rdy;
      bpat[i] = b_req_rdy;
      tick();
    end
    check("arb_any_grant", 64'(apat), 64'hF);
`ifdef FU_INC_ARB_RR_EN
    check("arb_b_pattern", 64'(bpat), 64'hA);
`else
    check("arb_b_pattern", 64'(bpat), 64'h0);
`endif
    apply_stimulus(0, 0, 0, 0, 0, 0, 1);
    repeat (4) tick();

    apply_stimulus(1, 56'h00_0000_0000_00FF, 4'h3, 0, 0, 0, 1);
    tick();
    apply_stimulus(0, 0, 0, 0, 0, 0, 1);
    check_output("inc_ff", 56'h00_0000_0000_0100, 1'b0, 4'h3, 1'b0, w);
    check("latency", 64'(w), 64'd1);
    tick();

    apply_stimulus(0, 0, 0, 1, 56'hFF_FFFF_FFFF_FFFF, 4'h5, 1);
    tick();
    apply_stimulus(0, 0, 0, 0, 0, 0, 1);
    check_output("all_ones", 56'h0, 1'b1, 4'h5, 1'b1, w);
    tick();

    apply_stimulus(1, 56'h12_FFFF_FFFF_FFFF, 4'hA, 0, 0, 0, 1);
    tick();
    apply_stimulus(0, 0, 0, 0, 0, 0, 1);
    check_output("carry6", 56'h13_0000_0000_0000, 1'b0, 4'hA, 1'b0, w);
    tick();

    apply_stimulus(0, 0, 0, 1, 56'h00_00FF_00FF_FFFF, 4'h6, 1);
    tick();
    apply_stimulus(0, 0, 0, 0, 0, 0, 1);
    check_output("carry_stop", 56'h00_00FF_0100_0000, 1'b0, 4'h6, 1'b1, w);
    tick();

    // Back-to-back: one request per cycle streams out one result per cycle.
    fork
      begin
        apply_stimulus(1, 56'h10, 4'h7, 0, 0, 0, 1);
        tick();
        apply_stimulus(1, 56'h20, 4'h8, 0, 0, 0, 1);
        tick();
        apply_stimulus(1, 56'h3FF, 4'h9, 0, 0, 0, 1);
        tick();
        apply_stimulus(0, 0, 0, 0, 0, 0, 1);
      end
      begin
        check_output("stream0", 56'h11, 1'b0, 4'h7, 1'b0, w);
        check_output("stream1", 56'h21, 1'b0, 4'h8, 1'b0, w);
        check("stream1_gap", 64'(w), 64'd0);
        check_output("stream2", 56'h400, 1'b0, 4'h9, 1'b0, w);
        check("stream2_gap", 64'(w), 64'd0);
      end
    join
    repeat (2) tick();

    // Stall with both stages full, then drain in order.
    apply_stimulus(1, 56'h40, 4'h1, 0, 0, 0, 0);
    tick();
    apply_stimulus(1, 56'h41, 4'h2, 0, 0, 0, 0);
    tick();
    apply_stimulus(1, 56'h42, 4'h3, 1, 56'h43, 4'h4, 0);
    for (int i = 0; i < 3; i++) begin
      @(negedge nclk);
      check("stall_a_rdy", 64'(a_req_rdy), 64'd0);
      check("stall_b_rdy", 64'(b_req_rdy), 64'd0);
      check("stall_out_data", 64'(out_data), 64'h41);
      check("stall_out_tag", 64'(out_tag), 64'h1);
      tick();
    end
    apply_stimulus(0, 0, 0, 0, 0, 0, 1);
    check_output("drain0", 56'h41, 1'b0, 4'h1, 1'b0, w);
    check_output("drain1", 56'h42, 1'b0, 4'h2, 1'b0, w);
    check("drain1_gap", 64'(w), 64'd0);
    tick();
    @(negedge nclk);
    check("drained_busy", 64'(busy), 64'd0);
    tick();

    // Asynchronous reset with both stages full.
    apply_stimulus(1, 56'h50, 4'h5, 0, 0, 0, 0);
    tick();
    apply_stimulus(1, 56'h51, 4'h6, 0, 0, 0, 0);
    tick();
    apply_stimulus(0, 0, 0, 0, 0, 0, 0);
    #2;
    check("full_busy", 64'(busy), 64'd1);
    reset_b = 1'b0;
    #1;
    check("async_out_v", 64'(out_v), 64'd0);
    check("async_busy", 64'(busy), 64'd0);
    check("async_out_data", 64'(out_data), 64'd0);
    tick();
    reset_b = 1'b1;
    apply_stimulus(1, 56'h07, 4'h4, 0, 0, 0, 1);
    @(negedge nclk);
    check("first_accept_rdy", 64'(a_req_rdy), 64'd1);
    tick();
    apply_stimulus(0, 0, 0, 0, 0, 0, 1);
    @(negedge nclk);
    check("no_stale_out_v", 64'(out_v), 64'd0);
    check_output("post_reset", 56'h08, 1'b0, 4'h4, 1'b0, w);
    check("post_reset_latency", 64'(w), 64'd0);
    repeat (3) tick();
    @(negedge nclk);
    check("final_idle", 64'(busy), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
